// File: rtl/dram_port_arbiter_pkg.sv
// Shared definitions for the DRAM port arbiter:
// FSM state encoding and load/store size-code constants.
package dram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam int          DW                = 32;
  localparam int          CTRL_W            = 3;
  localparam logic [1:0]  SZ_BYTE           = 2'd0;
  localparam logic [1:0]  SZ_HALF           = 2'd1;
  localparam logic [1:0]  SZ_WORD           = 2'd2;
  localparam int          CTRL_UNSIGNED_BIT = 2;

endpackage

// File: rtl/dram_port_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority selector.
// Ports: i_req (request vector), i_last (last grant),
//        o_onehot / o_idx (winner), o_valid (any request).
module rr_pick #(
  parameter  int N  = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % N);
  endfunction

  // Search starts one past the last winner and wraps.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!o_valid && i_req[wrap(int'(i_last) + k)]) begin
        o_valid = 1'b1;
        o_idx   = wrap(int'(i_last) + k);
      end
    end
    if (o_valid) o_onehot[o_idx] = 1'b1;
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares one DRAM controller among N_PORTS
// requesters (round-robin or fixed priority).
// Ports: clk/rst; per-port i_req/i_we/i_addr/i_wdata/i_ctrl,
//   o_ack, shared o_rdata; controller side o_rd_en/o_wr_en,
//   o_addr/o_data/o_ctrl, i_busy/i_rdata/i_init_done;
//   status o_grant/o_active.
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter  int N_PORTS = 3,
  parameter  bit RR_EN   = 1'b1,
  localparam int GW      = $clog2(N_PORTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_PORTS-1:0]       i_req,
  input  logic [N_PORTS-1:0]       i_we,
  input  logic [DW*N_PORTS-1:0]    i_addr,
  input  logic [DW*N_PORTS-1:0]    i_wdata,
  input  logic [CTRL_W*N_PORTS-1:0] i_ctrl,
  output logic [N_PORTS-1:0]       o_ack,
  output logic [DW-1:0]            o_rdata,
  output logic                     o_rd_en,
  output logic                     o_wr_en,
  output logic [DW-1:0]            o_addr,
  output logic [DW-1:0]            o_data,
  output logic [CTRL_W-1:0]        o_ctrl,
  input  logic                     i_busy,
  input  logic [DW-1:0]            i_rdata,
  input  logic                     i_init_done,
  output logic [GW-1:0]            o_grant,
  output logic                     o_active
);

  arb_state_e          state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_q, last_d;
  logic                rd_en_q, rd_en_d;
  logic                wr_en_q, wr_en_d;
  logic                store_q, store_d;
  logic [N_PORTS-1:0]  ack_q, ack_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [DW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       data_q, data_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;

  logic [GW-1:0]       pick_last;
  logic [N_PORTS-1:0]  pick_oh;
  logic [GW-1:0]       pick_idx;
  logic                pick_valid;
  logic [DW-1:0]       sel_addr;
  logic [DW-1:0]       sel_data;
  logic [CTRL_W-1:0]   sel_ctrl;
  logic                sel_we;

  // Fixed priority is the rotating search pinned to start at 0.
  assign pick_last = RR_EN ? last_q : GW'(N_PORTS - 1);

  rr_pick #(.N(N_PORTS)) u_pick (
    .i_req    (i_req),
    .i_last   (pick_last),
    .o_onehot (pick_oh),
    .o_idx    (pick_idx),
    .o_valid  (pick_valid)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_ctrl = '0;
    sel_we   = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (pick_oh[p]) begin
        sel_addr = i_addr[p*DW +: DW];
        sel_data = i_wdata[p*DW +: DW];
        sel_ctrl = i_ctrl[p*CTRL_W +: CTRL_W];
        sel_we   = i_we[p];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rd_en_d = rd_en_q;
    wr_en_d = wr_en_q;
    store_d = store_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    unique case (state_q)
      ST_IDLE: begin
        // No grant in the ack cycle: the retiring port may
        // still show its old request level.
        if (i_init_done && !i_busy && pick_valid &&
            ack_q == '0) begin
          grant_d = pick_idx;
          addr_d  = sel_addr;
          data_d  = sel_data;
          ctrl_d  = sel_ctrl;
          rd_en_d = !sel_we;
          wr_en_d = sel_we;
          store_d = sel_we;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_busy) begin
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!i_busy) begin
          if (!store_q) rdata_d = i_rdata;
          ack_d[grant_q] = 1'b1;
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_PORTS - 1);
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      store_q <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      store_q <= store_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign o_ack    = ack_q;
  assign o_rdata  = rdata_q;
  assign o_rd_en  = rd_en_q;
  assign o_wr_en  = wr_en_q;
  assign o_addr   = addr_q;
  assign o_data   = data_q;
  assign o_ctrl   = ctrl_q;
  assign o_grant  = grant_q;
  assign o_active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Testbench for dram_port_arbiter: DUT 0 round-robin,
// DUT 1 fixed priority, each with its own controller model.
module tb_dram_port_arbiter;
  import dram_port_arbiter_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [N-1:0]       req   [2];
  logic [N-1:0]       we    [2];
  logic [32*N-1:0]    addr  [2];
  logic [32*N-1:0]    wdata [2];
  logic [3*N-1:0]     ctrl  [2];
  logic [N-1:0]       ack   [2];
  logic [31:0]        rdata [2];
  logic [31:0]        oaddr [2];
  logic [31:0]        odata [2];
  logic [2:0]         octrl [2];
  logic [1:0]         grant [2];
  logic [31:0]        crdata [2];
  logic [31:0]        next_rd [2];
  int                 cnt [2];
  int                 lat [2];
  logic [1:0]         rd_en, wr_en, active;
  logic [1:0]         busy, cbusy, refresh, init_done;

  int vectors = 0;
  int errors  = 0;

  assign busy = cbusy | refresh;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    dram_port_arbiter #(.N_PORTS(N), .RR_EN(d == 0)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .i_req       (req[d]),
      .i_we        (we[d]),
      .i_addr      (addr[d]),
      .i_wdata     (wdata[d]),
      .i_ctrl      (ctrl[d]),
      .o_ack       (ack[d]),
      .o_rdata     (rdata[d]),
      .o_rd_en     (rd_en[d]),
      .o_wr_en     (wr_en[d]),
      .o_addr      (oaddr[d]),
      .o_data      (odata[d]),
      .o_ctrl      (octrl[d]),
      .i_busy      (busy[d]),
      .i_rdata     (crdata[d]),
      .i_init_done (init_done[d]),
      .o_grant     (grant[d]),
      .o_active    (active[d])
    );
  end

  // Controller model: accepts a strobe one cycle after it
  // appears, then stays busy for lat cycles.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        cbusy[d]  <= 1'b0;
        cnt[d]    <= 0;
        crdata[d] <= '0;
      end else if (!cbusy[d] && (rd_en[d] || wr_en[d])) begin
        cbusy[d] <= 1'b1;
        cnt[d]   <= lat[d];
        if (rd_en[d]) crdata[d] <= next_rd[d];
      end else if (cbusy[d]) begin
        if (cnt[d] <= 1) cbusy[d] <= 1'b0;
        cnt[d] <= cnt[d] - 1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_pick(input logic [N-1:0] r,
                                  input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_port(input int d, input int p,
                          input logic w, input logic [31:0] a,
                          input logic [31:0] dt,
                          input logic [2:0] c);
    we[d][p]            = w;
    addr[d][p*32 +: 32] = a;
    wdata[d][p*32 +: 32] = dt;
    ctrl[d][p*3 +: 3]   = c;
  endtask

  task automatic rand_port(input int d, input int p);
    logic [2:0] c;
    case ($urandom_range(0, 2))
      0:       c[1:0] = SZ_BYTE;
      1:       c[1:0] = SZ_HALF;
      default: c[1:0] = SZ_WORD;
    endcase
    c[CTRL_UNSIGNED_BIT] = 1'($urandom_range(0, 1));
    set_port(d, p, 1'($urandom_range(0, 1)), $urandom,
             $urandom, c);
  endtask

  task automatic wait_ack(input int d, input int budget,
                          output int port);
    port = -1;
    for (int k = 0; k < budget && port < 0; k++) begin
      @(negedge clk);
      if (ack[d] != '0) port = oh2i(ack[d]);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    refresh   = 2'b00;
    init_done = 2'b11;
    for (int d = 0; d < 2; d++) begin
      req[d] = '0;
      lat[d] = 1;
      next_rd[d] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      we[d] = '0; addr[d] = '0; wdata[d] = '0; ctrl[d] = '0;
    end
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({ack[d], rdata[d], rd_en[d], wr_en[d], oaddr[d],
           odata[d], octrl[d], grant[d], active[d]} !== '0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %h/%h/%b%b/%h/%h/%h/%0d/%b want all zero",
                 d, ack[d], rdata[d], rd_en[d], wr_en[d],
                 oaddr[d], odata[d], octrl[d], grant[d], active[d]);
      end
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (active !== 2'b00 || (rd_en | wr_en) !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_req: active=%b strobes=%b want 00",
               active, rd_en | wr_en);
    end
  endtask

  task automatic test_single_load();
    int strobes = 0;
    int got = -1;
    lat[0] = 6;
    next_rd[0] = 32'hDEADBEEF;
    set_port(0, 1, 1'b0, 32'h100, 32'h5A5A5A5A, 3'd2);
    req[0] = 3'b010;
    for (int k = 1; k <= 60 && got < 0; k++) begin
      @(negedge clk);
      if (rd_en[0]) begin
        strobes++;
        if (strobes == 1) begin
          vectors++;
          if (grant[0] !== 2'd1 || oaddr[0] !== 32'h100 ||
              octrl[0] !== 3'd2 || wr_en[0] !== 1'b0) begin
            errors++;
            $display("FAIL load_cmd: grant=%0d addr=%h ctrl=%0d we=%b want 1/100/2/0",
                     grant[0], oaddr[0], octrl[0], wr_en[0]);
          end
        end
      end
      if (ack[0] != '0) begin
        got = k;
        vectors++;
        if (ack[0] !== 3'b010 || rdata[0] !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL load_ack: ack=%b rdata=%h want 010/deadbeef",
                   ack[0], rdata[0]);
        end
      end
    end
    req[0] = '0;
    vectors++;
    if (got != 9) begin
      errors++;
      $display("FAIL load_latency: got %0d want 9", got);
    end
    vectors++;
    if (strobes != 2) begin
      errors++;
      $display("FAIL strobe_hold: got %0d cycles want 2", strobes);
    end
    @(negedge clk);
    vectors++;
    if (ack[0] !== '0) begin
      errors++;
      $display("FAIL ack_pulse: ack=%b want 000", ack[0]);
    end
  endtask

  // Store with the request dropped early: must still retire.
  task automatic test_min_latency();
    int got = -1;
    lat[0] = 1;
    set_port(0, 2, 1'b1, 32'h203, 32'h12345678, 3'd5);
    req[0] = 3'b100;
    for (int k = 1; k <= 30 && got < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req[0] = '0;
        vectors++;
        if (wr_en[0] !== 1'b1 || odata[0] !== 32'h12345678 ||
            octrl[0] !== 3'd5 || rd_en[0] !== 1'b0) begin
          errors++;
          $display("FAIL store_cmd: wr=%b rd=%b data=%h ctrl=%0d want 1/0/12345678/5",
                   wr_en[0], rd_en[0], odata[0], octrl[0]);
        end
      end
      if (ack[0] != '0) begin
        got = k;
        vectors++;
        if (ack[0] !== 3'b100 || rdata[0] !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL store_ack: ack=%b rdata=%h want 100/deadbeef",
                   ack[0], rdata[0]);
        end
      end
    end
    vectors++;
    if (got != 4) begin
      errors++;
      $display("FAIL min_latency: got %0d want 4", got);
    end
  endtask

  task automatic test_contention();
    int order [6] = '{0, 1, 2, 0, 1, 2};
    int n = 0;
    lat[0] = 2;
    for (int p = 0; p < N; p++)
      set_port(0, p, 1'b0, 32'h1000 + 32'(p), 32'h0, 3'd2);
    req[0] = 3'b111;
    for (int k = 0; k < 300 && n < 6; k++) begin
      @(negedge clk);
      if (ack[0] != '0) begin
        vectors++;
        if (oh2i(ack[0]) != order[n]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d want %0d",
                   n, oh2i(ack[0]), order[n]);
        end
        n++;
        if (n == 6) req[0] = '0;
      end
    end
    vectors++;
    if (n != 6) begin
      errors++;
      $display("FAIL rr_timeout: got %0d acks want 6", n);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (active[0] !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain: active=%b want 0", active[0]);
    end
  endtask

  task automatic test_fixed();
    int cyc = 0;
    int n = 0;
    int p2 = 0;
    int got;
    lat[1] = 1;
    set_port(1, 0, 1'b0, 32'h40, 32'h0, 3'd0);
    set_port(1, 2, 1'b1, 32'h80, 32'hCAFE0002, 3'd1);
    req[1] = 3'b101;
    for (int k = 0; k < 300 && n < 5; k++) begin
      @(negedge clk);
      cyc++;
      if (ack[1] != '0) begin
        if (oh2i(ack[1]) == 2) p2++;
        n++;
        if (n == 5) req[1] = 3'b100;
      end
    end
    vectors++;
    if (n != 5 || p2 != 0) begin
      errors++;
      $display("FAIL fixed_prio: acks=%0d port2_grants=%0d want 5/0",
               n, p2);
    end
    $display("starvation: port 2 waited %0d cycles with no grant",
             cyc);
    wait_ack(1, 40, got);
    req[1] = '0;
    vectors++;
    if (got != 2) begin
      errors++;
      $display("FAIL fixed_release: got port %0d want 2", got);
    end
  endtask

  task automatic test_busy_idle();
    int bad = 0;
    int got;
    refresh[0] = 1'b1;
    set_port(0, 1, 1'b0, 32'h300, 32'h0, 3'd2);
    req[0] = 3'b010;
    repeat (20) begin
      @(negedge clk);
      if (rd_en[0] || wr_en[0] || active[0]) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL busy_idle: %0d cycles with grant want 0", bad);
    end
    refresh[0] = 1'b0;
    @(negedge clk);
    vectors++;
    if (active[0] !== 1'b1 || rd_en[0] !== 1'b1 ||
        grant[0] !== 2'd1) begin
      errors++;
      $display("FAIL busy_release: act=%b rd=%b grant=%0d want 1/1/1",
               active[0], rd_en[0], grant[0]);
    end
    wait_ack(0, 30, got);
    req[0] = '0;
    vectors++;
    if (got != 1) begin
      errors++;
      $display("FAIL busy_ack: got port %0d want 1", got);
    end
  endtask

  task automatic test_init_gating();
    int bad = 0;
    int got;
    init_done[0] = 1'b0;
    set_port(0, 0, 1'b1, 32'h500, 32'h77, 3'd2);
    req[0] = 3'b001;
    repeat (15) begin
      @(negedge clk);
      if (rd_en[0] || wr_en[0] || ack[0] != '0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL init_gate: %0d cycles with activity want 0",
               bad);
    end
    init_done[0] = 1'b1;
    wait_ack(0, 30, got);
    req[0] = '0;
    vectors++;
    if (got != 0) begin
      errors++;
      $display("FAIL init_service: got port %0d want 0", got);
    end
  endtask

  task automatic test_reset_midop();
    int got;
    int hit = 0;
    int acks = 0;
    lat[0] = 1;
    next_rd[0] = 32'h0BADF00D;
    set_port(0, 0, 1'b0, 32'h600, 32'h0, 3'd2);
    req[0] = 3'b001;
    wait_ack(0, 30, got);
    req[0] = '0;
    @(negedge clk);
    lat[0] = 10;
    set_port(0, 2, 1'b0, 32'hABCD0010, 32'h0, 3'd6);
    req[0] = 3'b100;
    for (int k = 0; k < 30 && hit == 0; k++) begin
      @(negedge clk);
      if (active[0] && !rd_en[0] && !wr_en[0]) hit = 1;
    end
    vectors++;
    if (hit == 0) begin
      errors++;
      $display("FAIL midop_reach: wait state not reached");
    end
    rst = 1'b1;
    req[0] = '0;
    @(negedge clk);
    vectors++;
    if ({ack[0], rdata[0], rd_en[0], wr_en[0], oaddr[0],
         odata[0], octrl[0], grant[0], active[0]} !== '0) begin
      errors++;
      $display("FAIL midop_reset: ack=%b rdata=%h addr=%h ctrl=%0d grant=%0d act=%b want zeros",
               ack[0], rdata[0], oaddr[0], octrl[0], grant[0],
               active[0]);
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ack[0] != '0) acks++;
    end
    vectors++;
    if (acks != 0) begin
      errors++;
      $display("FAIL midop_no_ack: got %0d acks want 0", acks);
    end
    lat[0] = 1;
    set_port(0, 1, 1'b0, 32'h700, 32'h0, 3'd2);
    req[0] = 3'b011;
    wait_ack(0, 30, got);
    req[0] = '0;
    vectors++;
    if (got != 0) begin
      errors++;
      $display("FAIL last_grant_reset: got port %0d want 0", got);
    end
  endtask

  task automatic test_random(input int d, input int ntx);
    int rem [N];
    int gap [N];
    logic [N-1:0] prev_req = '0;
    logic [31:0] exp_rd = '0;
    bit was_act = 0;
    bit ack_prev = 0;
    bit outst = 0;
    bit done = 0;
    int ref_last = N - 1;
    int ep = 0;
    int e;
    for (int p = 0; p < N; p++) begin
      rem[p] = ntx;
      gap[p] = $urandom_range(0, 3);
    end
    req[d] = '0;
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      @(negedge clk);
      lat[d] = $urandom_range(1, 4);
      next_rd[d] = $urandom;
      vectors++;
      if ((rd_en[d] || wr_en[d]) && !active[d]) begin
        errors++;
        $display("FAIL strobe_idle dut%0d: strobe in idle", d);
      end
      if (active[d] && !was_act) begin
        e = ref_pick(prev_req, d == 0 ? ref_last : N - 1);
        vectors++;
        if (ack_prev || e < 0) begin
          errors++;
          $display("FAIL grant_timing dut%0d: ack_prev=%0b ref=%0d",
                   d, ack_prev, e);
        end
        if (e >= 0) begin
          vectors++;
          if (grant[d] !== 2'(e)) begin
            errors++;
            $display("FAIL grant dut%0d: got %0d want %0d",
                     d, grant[d], e);
          end
          vectors++;
          if ({rd_en[d], wr_en[d], oaddr[d], odata[d], octrl[d]}
              !== {~we[d][e], we[d][e], addr[d][e*32 +: 32],
                   wdata[d][e*32 +: 32], ctrl[d][e*3 +: 3]}) begin
            errors++;
            $display("FAIL payload dut%0d: rd=%b wr=%b a=%h d=%h c=%0d port %0d",
                     d, rd_en[d], wr_en[d], oaddr[d], odata[d],
                     octrl[d], e);
          end
          ep = e;
          outst = 1;
        end
      end
      if (ack[d] != '0) begin
        vectors++;
        if (!outst || ack[d] !== N'(1 << ep)) begin
          errors++;
          $display("FAIL ack dut%0d: got %b want port %0d outst=%0b",
                   d, ack[d], ep, outst);
        end
        if (outst) begin
          if (!we[d][ep]) exp_rd = crdata[d];
          vectors++;
          if (rdata[d] !== exp_rd) begin
            errors++;
            $display("FAIL rdata dut%0d: got %h want %h",
                     d, rdata[d], exp_rd);
          end
          ref_last = ep;
          rem[ep]--;
          req[d][ep] = 1'b0;
          outst = 0;
          if (rem[ep] > 0 && $urandom_range(0, 1) == 1) begin
            rand_port(d, ep);
            req[d][ep] = 1'b1;
          end else begin
            gap[ep] = $urandom_range(1, 3);
          end
        end
      end
      for (int p = 0; p < N; p++) begin
        if (!req[d][p] && rem[p] > 0) begin
          if (gap[p] > 0) gap[p]--;
          else begin
            rand_port(d, p);
            req[d][p] = 1'b1;
          end
        end
      end
      was_act  = active[d];
      ack_prev = (ack[d] != '0);
      prev_req = req[d];
      done = !active[d] && !outst && req[d] == '0 &&
             rem[0] == 0 && rem[1] == 0 && rem[2] == 0;
    end
    vectors++;
    if (!done) begin
      errors++;
      $display("FAIL random_timeout dut%0d: left %0d/%0d/%0d",
               d, rem[0], rem[1], rem[2]);
    end
  endtask

  initial begin
    test_reset();
    do_reset();
    test_single_load();
    test_min_latency();
    do_reset();
    test_contention();
    do_reset();
    test_fixed();
    do_reset();
    test_busy_idle();
    do_reset();
    test_init_gating();
    do_reset();
    test_reset_midop();
    do_reset();
    test_random(0, 10);
    do_reset();
    test_random(1, 6);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
